input_debounce: RTL

//  Fabric-side stage directly downstream of the AP3 input cell: consumes the cell output IQZ
//  (in_buff or in_reg mode) and turns it into a glitch-free, clock-domain-safe level.

---
 rtl/input_debounce.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/input_debounce.sv
// input_debounce
// Fabric-side conditioning of the input-cell output IQZ. IQZ is brought into
// the clk domain through a short synchronizer chain. A small STABLE/CHECK FSM
// then accepts a new level only after DEBOUNCE_CYCLES consecutive differing
// samples, and emits a one-cycle rise/fall strobe aligned with the new level.
// Selected edges feed a saturating event counter with ack and sticky overflow.
module input_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned EDGE_SEL        = 0,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IQZ,
  input  logic             en,
  input  logic             evt_ack,
  output logic             dbc_level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] evt_count,
  output logic             evt_pending,
  output logic             overflow
);

  // Debounce counter only ever needs to hold values up to DEBOUNCE_CYCLES.
  localparam int unsigned      DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Synchronizer state
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  // ---------------------------------------------------------------------
  // Debounce FSM state and registered outputs
  // ---------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_d;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  // ---------------------------------------------------------------------
  // Event counter state
  // ---------------------------------------------------------------------
  logic             counted_edge;
  logic [CNT_W-1:0] evt_count_q;
  logic [CNT_W-1:0] evt_count_d;
  logic             evt_pending_q;
  logic             evt_pending_d;
  logic             overflow_q;
  logic             overflow_d;

  // Shift IQZ into the chain; only the last stage is used downstream.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], IQZ};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer flops; the only place IQZ is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Debounce decision: count consecutive samples differing from the accepted level.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;

    if (!en) begin
      // Frozen: drop any partial count, hold the level, keep quiet.
      state_d   = ST_STABLE;
      deb_cnt_d = '0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (s != level_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // A single differing sample is enough: accept right away.
              level_d   = s;
              rise_d    = s;
              fall_d    = ~s;
              deb_cnt_d = '0;
            end else begin
              state_d   = ST_CHECK;
              deb_cnt_d = DEB_W'(1);
            end
          end
        end

        ST_CHECK: begin
          if (s == level_q) begin
            // Input bounced back before qualifying: treat as a glitch.
            state_d   = ST_STABLE;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            level_d   = s;
            rise_d    = s;
            fall_d    = ~s;
            state_d   = ST_STABLE;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end

        default: begin
          state_d   = ST_STABLE;
          deb_cnt_d = '0;
        end
      endcase
    end
  end

  // Debounce FSM registers; strobes come out together with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STABLE;
      deb_cnt_q <= '0;
      level_q   <= RESET_LEVEL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  // Pick which registered strobes count as events.
  always_comb begin
    counted_edge = 1'b0;
    if (EDGE_SEL == 0) begin
      counted_edge = rise_q;
    end else if (EDGE_SEL == 1) begin
      counted_edge = fall_q;
    end else begin
      counted_edge = rise_q | fall_q;
    end
  end

  // Event counter: ack clears, but an edge arriving with the ack still counts.
  always_comb begin
    evt_count_d = evt_count_q;
    overflow_d  = overflow_q;

    if (evt_ack) begin
      evt_count_d = counted_edge ? CNT_W'(1) : '0;
      overflow_d  = 1'b0;
    end else if (counted_edge) begin
      if (evt_count_q == CNT_MAX) begin
        overflow_d = 1'b1;
      end
      evt_count_d = sat_inc(evt_count_q);
    end

    evt_pending_d = (evt_count_d != '0);
  end

  // Event counter registers; pending is registered from the same next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_count_q   <= '0;
      evt_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      evt_count_q   <= evt_count_d;
      evt_pending_q <= evt_pending_d;
      overflow_q    <= overflow_d;
    end
  end

  assign dbc_level   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign evt_count   = evt_count_q;
  assign evt_pending = evt_pending_q;
  assign overflow    = overflow_q;

endmodule
